// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared state encoding and constants for the clock-enable divider
package freq_div_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int MIN_DIV = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;
endpackage

// File: rtl/freq_div_core.sv
// freq_div_core: mod-N counter, tick decode and zero-latency div_out compare flop
module freq_div_core
  import freq_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] cur_div,
  input  logic [CNT_W-1:0] nxt_div,
  input  logic [CNT_W-1:0] nxt_duty,
  output logic             tick,
  output logic             div_out
);
  logic [CNT_W-1:0] cnt, cnt_n;
  assign tick = en & (cnt == cur_div - CNT_W'(1));
  // next count: idle or restart forces 0, otherwise wrap at cur_div-1
  always_comb begin
    cnt_n = (!en || clr || cnt >= cur_div - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
  end
  // div_out is compared against next-state values so it lines up with cnt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_out <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_out <= cnt_n >= nxt_div - nxt_duty;
    end
  end
endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable divider with valid/ready config handshake; optional resync port under FREQ_DIV_CTRL_RESYNC_EN
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_DIV  = 6,
  parameter int DEFAULT_DUTY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             pending
`ifdef FREQ_DIV_CTRL_RESYNC_EN
  ,
  input  logic             resync
`endif
);
  state_t state, state_n;
  logic [CNT_W-1:0] cur_duty, sh_div, sh_duty, nxt_div, nxt_duty, cl_duty;
  logic acc, good, direct, apply_sh, rs, clr;
`ifdef FREQ_DIV_CTRL_RESYNC_EN
  assign rs = resync & en;
`else
  assign rs = 1'b0;
`endif
  // handshake decode, duty clamp and selection of the config in force after this edge
  always_comb begin
    acc      = cfg_valid & cfg_ready;
    good     = acc & (cfg_div >= CNT_W'(MIN_DIV));
    cl_duty  = (cfg_duty >= cfg_div) ? cfg_div - CNT_W'(1) : cfg_duty;
    direct   = good & (state == IDLE || !en);
    apply_sh = (state == PEND) & (!en | tick | rs);
    nxt_div  = direct ? cfg_div : apply_sh ? sh_div : cur_div;
    nxt_duty = direct ? cl_duty : apply_sh ? sh_duty : cur_duty;
    clr      = apply_sh | rs;
    state_n  = !en ? IDLE : (state == PEND) ? (apply_sh ? RUN : PEND) :
               (good && state == RUN) ? PEND : RUN;
  end
  // FSM, active config, shadow registers and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_div   <= CNT_W'(DEFAULT_DIV);
      cur_duty  <= CNT_W'(DEFAULT_DUTY);
      sh_div    <= '0;
      sh_duty   <= '0;
      cfg_err   <= 1'b0;
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state    <= state_n;
      cur_div  <= nxt_div;
      cur_duty <= nxt_duty;
      if (good && !direct) begin
        sh_div  <= cfg_div;
        sh_duty <= cl_duty;
      end
      cfg_err   <= acc & !good;
      pending   <= state_n == PEND;
      cfg_ready <= state_n != PEND;
    end
  end
  freq_div_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .cur_div (cur_div),
    .nxt_div (nxt_div),
    .nxt_duty(nxt_duty),
    .tick    (tick),
    .div_out (div_out)
  );
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed and random checks of freq_div_ctrl against a period/phase model
module tb_freq_div_ctrl;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0, cfg_duty = '0;
  logic cfg_ready, cfg_err, div_out, tick, pending;
  logic [7:0] cur_div;
  int n_chk = 0, n_fail = 0;
  int m_pos, m_div, m_duty, m_sdiv, m_sduty;
  bit m_pend, m_run, m_err;

  always #5 clk = ~clk;

  freq_div_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_duty (cfg_duty),
    .cfg_err  (cfg_err),
    .div_out  (div_out),
    .tick     (tick),
    .cur_div  (cur_div),
    .pending  (pending)
`ifdef FREQ_DIV_CTRL_RESYNC_EN
    ,
    .resync   (1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pos = 0; m_div = 6; m_duty = 3; m_sdiv = 0; m_sduty = 0;
    m_pend = 0; m_run = 0; m_err = 0;
  endtask

  // one clock: check outputs against the model, then advance the model over the edge
  task automatic cyc();
    bit acc, good;
    int cd;
    @(negedge clk);
    chk("tick", tick, (en && m_pos == m_div - 1) ? 1 : 0);
    chk("div_out", div_out, (m_pos >= m_div - m_duty) ? 1 : 0);
    chk("cfg_ready", cfg_ready, m_pend ? 0 : 1);
    chk("pending", pending, m_pend ? 1 : 0);
    chk("cur_div", cur_div, m_div);
    chk("cfg_err", cfg_err, m_err ? 1 : 0);
    acc  = cfg_valid && !m_pend;
    good = acc && cfg_div >= 2;
    cd   = (cfg_duty >= cfg_div) ? int'(cfg_div) - 1 : int'(cfg_duty);
    m_err = acc && !good;
    if (!en) begin
      if (m_pend) begin m_div = m_sdiv; m_duty = m_sduty; end
      if (good) begin m_div = cfg_div; m_duty = cd; end
      m_pend = 0; m_run = 0; m_pos = 0;
    end else begin
      bit wrap;
      wrap = (m_pos == m_div - 1);
      if (m_pend && wrap) begin
        m_div = m_sdiv; m_duty = m_sduty; m_pend = 0;
      end else if (good && !m_run) begin
        m_div = cfg_div; m_duty = cd;
      end else if (good) begin
        m_sdiv = cfg_div; m_sduty = cd; m_pend = 1;
      end
      m_pos = wrap ? 0 : m_pos + 1;
      m_run = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int d, input int u);
    cfg_valid = 1'b1; cfg_div = 8'(d); cfg_duty = 8'(u);
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    #3 reset = 1'b0;
    #1;
    chk("rst_div_out", div_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_pending", pending, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cur_div", cur_div, 6);
    @(posedge clk);
    #1 reset = 1'b1;
    en = 1'b1;
    repeat (14) cyc();
    cfg(1, 0);
    repeat (3) cyc();
    for (int i = 0; i < 20 && m_pos != 2; i++) cyc();
    cfg(5, 1);
    repeat (14) cyc();
    cfg(4, 9);
    repeat (16) cyc();
    for (int i = 0; i < 20 && m_pos != 1; i++) cyc();
    cfg(7, 2);
    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 20 && m_pos != 0; i++) cyc();
    cfg(9, 4);
    for (int i = 0; i < 20 && !(m_pend && m_pos == 3); i++) cyc();
    #2 reset = 1'b0;
    #1;
    en = 1'b0;
    chk("mid_rst_div_out", div_out, 0);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_cur_div", cur_div, 6);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    en = 1'b1;
    repeat (8) cyc();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 16) != 0;
      cfg_valid = ($urandom % 6) == 0;
      cfg_div = 8'($urandom_range(0, 12));
      cfg_duty = 8'($urandom_range(0, 14));
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
